// File: rtl/div_unit.sv
// Restoring 32-bit divider (signed/unsigned), one quotient bit per cycle, result {rem, quo}.
// Optional DIV_UNIT_EARLY_OUT_EN: finish early when |dividend| < |divisor|.
module div_unit #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_div_i,
  input  logic [DW-1:0]     opdata1_i,
  input  logic [DW-1:0]     opdata2_i,
  output logic [2*DW-1:0]   result_o,
  output logic              ready_o
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      quo_q, quo_d;
  logic [DW-1:0]      rem_q, rem_d;
  logic [DW-1:0]      dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*DW-1:0]    result_d;
  logic               ready_d;

  logic               op1_neg, op2_neg;
  logic [DW-1:0]      op1_mag, op2_mag;
  logic [DW:0]        shift_rem, diff;
  logic               sub_ok;
  logic [DW-1:0]      rem_step, quo_step;

  assign op1_neg = signed_div_i & opdata1_i[DW-1];
  assign op2_neg = signed_div_i & opdata2_i[DW-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
  assign shift_rem = {rem_q, quo_q[DW-1]};
  assign diff      = shift_rem - {1'b0, dvs_q};
  assign sub_ok    = shift_rem >= {1'b0, dvs_q};
  assign rem_step  = sub_ok ? diff[DW-1:0] : shift_rem[DW-1:0];
  assign quo_step  = {quo_q[DW-2:0], sub_ok};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_o;
    ready_d   = ready_o;
    case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        cnt_d    = '0;
        if (start_i && !annul_i) begin
          quo_d     = op1_mag;
          rem_d     = '0;
          dvs_d     = op2_mag;
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          if (opdata2_i == '0) begin
            state_d = BY_ZERO;
            quo_d   = '0;
`ifdef DIV_UNIT_EARLY_OUT_EN
          end else if (op1_mag < op2_mag) begin
            // short path reuses BY_ZERO: {rem_q, quo_q} already holds the final answer
            state_d = BY_ZERO;
            quo_d   = '0;
            rem_d   = opdata1_i;
`endif
          end else begin
            state_d = ON;
          end
        end
      end
      BY_ZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = {rem_q, quo_q};
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          quo_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == CNT_W'(DW - 1)) begin
            state_d  = END;
            result_d = {neg_rem_q ? -rem_step : rem_step,
                        neg_quo_q ? -quo_step : quo_step};
            ready_d  = 1'b1;
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule
